// File: rtl/systolic_pe_v2.sv
// Systolic-array processing element: output-stationary MAC with psum drain chain, or weight-stationary psum adder.
// Defining PE_SAT_EN compiles in saturating accumulation and the sticky ovf flag.
module systolic_pe_v2 #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              clear,
  input  logic              drain,
  input  logic              load_w,
  input  logic [DATA_W-1:0] in_a,
  input  logic              in_a_valid,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_b_valid,
  input  logic [ACC_W-1:0]  in_psum,
  input  logic              in_psum_valid,
  output logic [DATA_W-1:0] out_a,
  output logic              out_a_valid,
  output logic [DATA_W-1:0] out_b,
  output logic              out_b_valid,
  output logic [ACC_W-1:0]  out_psum,
  output logic              out_psum_valid,
  output logic              w_loaded,
  output logic              ovf
);

  typedef enum logic {
    S_ACC   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                   r_state;
  logic                     r_mode;
  logic signed [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0]        r_w;
  logic                     r_ovf;

  logic                     w_pair;
  logic                     w_mode_chg;
  logic [DATA_W-1:0]        w_mul_b;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_add_lhs;
  logic signed [ACC_W-1:0]  w_sum_raw;
  logic signed [ACC_W-1:0]  w_sum;
  logic                     w_clamp;

  assign w_pair     = in_a_valid & in_b_valid;
  assign w_mode_chg = mode ^ r_mode;

  // One multiplier serves both dataflows: OS multiplies the streamed B, WS the stationary weight.
  assign w_mul_b    = mode ? r_w : in_b;
  assign w_prod     = $signed(in_a) * $signed(w_mul_b);
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_add_lhs  = mode ? $signed(in_psum) : r_acc;
  assign w_sum_raw  = w_add_lhs + w_prod_ext;

`ifdef PE_SAT_EN
  function automatic logic [ACC_W-1:0] sat_limit(input logic neg);
    sat_limit = neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  logic w_sum_ovf;
  // Signed overflow: operands share a sign that the result does not.
  assign w_sum_ovf = (w_add_lhs[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                     (w_sum_raw[ACC_W-1] != w_add_lhs[ACC_W-1]);
  assign w_clamp   = w_sum_ovf;
  assign w_sum     = w_sum_ovf ? $signed(sat_limit(w_add_lhs[ACC_W-1])) : w_sum_raw;
`else
  assign w_clamp   = 1'b0;
  assign w_sum     = w_sum_raw;
`endif

  assign ovf = r_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_a          <= {DATA_W{1'b0}};
      out_a_valid    <= 1'b0;
      out_b          <= {DATA_W{1'b0}};
      out_b_valid    <= 1'b0;
      out_psum       <= {ACC_W{1'b0}};
      out_psum_valid <= 1'b0;
      w_loaded       <= 1'b0;
      r_ovf          <= 1'b0;
      r_acc          <= {ACC_W{1'b0}};
      r_w            <= {DATA_W{1'b0}};
      r_state        <= S_ACC;
      r_mode         <= 1'b0;
    end else begin
      out_a       <= in_a;
      out_a_valid <= in_a_valid;
      out_b       <= in_b;
      out_b_valid <= in_b_valid;
      r_mode      <= mode;
      if (w_mode_chg) begin
        r_acc          <= {ACC_W{1'b0}};
        r_w            <= {DATA_W{1'b0}};
        w_loaded       <= 1'b0;
        r_ovf          <= 1'b0;
        r_state        <= S_ACC;
        out_psum_valid <= 1'b0;
      end else if (!mode) begin
        case (r_state)
          S_ACC: begin
            // Drain takes priority over a coincident operand pair.
            if (drain) begin
              out_psum       <= r_acc;
              out_psum_valid <= 1'b1;
              r_acc          <= {ACC_W{1'b0}};
              r_state        <= S_DRAIN;
            end else begin
              out_psum_valid <= 1'b0;
              if (clear) begin
                r_acc <= w_pair ? w_prod_ext : {ACC_W{1'b0}};
              end else if (w_pair) begin
                r_acc <= w_sum;
                r_ovf <= r_ovf | w_clamp;
              end
            end
          end
          S_DRAIN: begin
            out_psum       <= in_psum;
            out_psum_valid <= in_psum_valid;
            if (!drain) begin
              r_state <= S_ACC;
            end
          end
          default: begin
            r_state        <= S_ACC;
            out_psum_valid <= 1'b0;
          end
        endcase
      end else begin
        if (in_a_valid) begin
          out_psum_valid <= in_psum_valid;
          if (w_loaded) begin
            out_psum <= w_sum;
            r_ovf    <= r_ovf | w_clamp;
          end else begin
            out_psum <= in_psum;
          end
        end else begin
          out_psum_valid <= 1'b0;
        end
        // A weight loaded here is first used on the next cycle.
        if (load_w && in_b_valid) begin
          r_w      <= in_b;
          w_loaded <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_pe_v2.sv
// Bench for systolic_pe_v2: a 3-row column (DATA_W=8, ACC_W=16) checked every cycle against an arithmetic model,
// plus directed literal expectations from the test plan. Honours PE_SAT_EN for saturation expectations.
module tb_systolic_pe_v2;
  localparam int DW = 8;
  localparam int AW = 16;

  logic clk, reset, mode, clear, drain, load_w;
  logic [DW-1:0] a [3];
  logic [DW-1:0] b [3];
  logic av [3];
  logic bv [3];
  logic [AW-1:0] psum0;
  logic psum0_v;
  logic [DW-1:0] oa [3];
  logic [DW-1:0] ob [3];
  logic oav [3];
  logic obv [3];
  logic [AW-1:0] po [3];
  logic pov [3];
  logic wl [3];
  logic ov [3];

  int n_checks = 0;
  int n_err = 0;

  systolic_pe_v2 #(.DATA_W(DW), .ACC_W(AW)) u_c0 (
    .clk(clk), .reset(reset), .mode(mode), .clear(clear), .drain(drain), .load_w(load_w),
    .in_a(a[0]), .in_a_valid(av[0]), .in_b(b[0]), .in_b_valid(bv[0]),
    .in_psum(psum0), .in_psum_valid(psum0_v),
    .out_a(oa[0]), .out_a_valid(oav[0]), .out_b(ob[0]), .out_b_valid(obv[0]),
    .out_psum(po[0]), .out_psum_valid(pov[0]), .w_loaded(wl[0]), .ovf(ov[0]));

  systolic_pe_v2 #(.DATA_W(DW), .ACC_W(AW)) u_c1 (
    .clk(clk), .reset(reset), .mode(mode), .clear(clear), .drain(drain), .load_w(load_w),
    .in_a(a[1]), .in_a_valid(av[1]), .in_b(b[1]), .in_b_valid(bv[1]),
    .in_psum(po[0]), .in_psum_valid(pov[0]),
    .out_a(oa[1]), .out_a_valid(oav[1]), .out_b(ob[1]), .out_b_valid(obv[1]),
    .out_psum(po[1]), .out_psum_valid(pov[1]), .w_loaded(wl[1]), .ovf(ov[1]));

  systolic_pe_v2 #(.DATA_W(DW), .ACC_W(AW)) u_c2 (
    .clk(clk), .reset(reset), .mode(mode), .clear(clear), .drain(drain), .load_w(load_w),
    .in_a(a[2]), .in_a_valid(av[2]), .in_b(b[2]), .in_b_valid(bv[2]),
    .in_psum(po[1]), .in_psum_valid(pov[1]),
    .out_a(oa[2]), .out_a_valid(oav[2]), .out_b(ob[2]), .out_b_valid(obv[2]),
    .out_psum(po[2]), .out_psum_valid(pov[2]), .w_loaded(wl[2]), .ovf(ov[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wrap or clamp an exact integer sum into the ACC_W signed range.
  function automatic longint fit(input longint s, output bit cl);
    longint lo, hi, span;
    lo = -(64'sd1 <<< (AW - 1));
    hi = (64'sd1 <<< (AW - 1)) - 1;
    span = 64'sd1 <<< AW;
    cl = 1'b0;
`ifdef PE_SAT_EN
    if (s > hi) begin cl = 1'b1; return hi; end
    if (s < lo) begin cl = 1'b1; return lo; end
`endif
    return ((s - lo) % span + span) % span + lo;
  endfunction

  // Behavioural model state per cell
  longint m_acc [3];
  longint m_w [3];
  longint m_op [3];
  bit m_wl [3], m_ovf [3], m_dr [3], m_mode [3], m_opv [3];
  logic [DW-1:0] m_oa [3];
  logic [DW-1:0] m_ob [3];
  bit m_oav [3], m_obv [3];
  bit live;
  longint t_pin, t_sa, t_sb;
  bit t_pinv, t_cl;

  // Cells are stepped bottom-up so each reads its northern neighbour's pre-edge psum.
  initial begin
    live = 1'b0;
    forever begin
      @(posedge clk);
      for (int k = 2; k >= 0; k--) begin
        if (k == 0) begin
          t_pin = longint'($signed(psum0));
          t_pinv = psum0_v;
        end else begin
          t_pin = m_op[k-1];
          t_pinv = m_opv[k-1];
        end
        t_sa = longint'($signed(a[k]));
        t_sb = longint'($signed(b[k]));
        if (reset) begin
          m_acc[k] = 0; m_w[k] = 0; m_op[k] = 0; m_opv[k] = 0;
          m_wl[k] = 0; m_ovf[k] = 0; m_dr[k] = 0; m_mode[k] = 0;
          m_oa[k] = '0; m_ob[k] = '0; m_oav[k] = 0; m_obv[k] = 0;
        end else begin
          m_oa[k] = a[k]; m_oav[k] = av[k]; m_ob[k] = b[k]; m_obv[k] = bv[k];
          if (mode != m_mode[k]) begin
            m_acc[k] = 0; m_w[k] = 0; m_wl[k] = 0; m_ovf[k] = 0; m_dr[k] = 0; m_opv[k] = 0;
          end else if (!mode) begin
            if (m_dr[k]) begin
              m_op[k] = t_pin; m_opv[k] = t_pinv;
              if (!drain) m_dr[k] = 0;
            end else if (drain) begin
              m_op[k] = m_acc[k]; m_opv[k] = 1; m_acc[k] = 0; m_dr[k] = 1;
            end else begin
              m_opv[k] = 0;
              if (clear) m_acc[k] = (av[k] && bv[k]) ? t_sa * t_sb : 0;
              else if (av[k] && bv[k]) begin
                m_acc[k] = fit(m_acc[k] + t_sa * t_sb, t_cl);
                m_ovf[k] |= t_cl;
              end
            end
          end else begin
            if (av[k]) begin
              if (m_wl[k]) begin
                m_op[k] = fit(t_pin + t_sa * m_w[k], t_cl);
                m_ovf[k] |= t_cl;
              end else m_op[k] = t_pin;
              m_opv[k] = t_pinv;
            end else m_opv[k] = 0;
            if (load_w && bv[k]) begin m_w[k] = t_sb; m_wl[k] = 1; end
          end
          m_mode[k] = mode;
        end
      end
      live = 1'b1;
    end
  end

  // Per-cycle comparison of every cell against the model
  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("c%0d out_a", k), oa[k], m_oa[k]);
          chk($sformatf("c%0d out_a_valid", k), oav[k], m_oav[k]);
          chk($sformatf("c%0d out_b", k), ob[k], m_ob[k]);
          chk($sformatf("c%0d out_b_valid", k), obv[k], m_obv[k]);
          chk($sformatf("c%0d out_psum_valid", k), pov[k], m_opv[k]);
          if (m_opv[k]) chk($sformatf("c%0d out_psum", k), $signed(po[k]), m_op[k]);
          chk($sformatf("c%0d w_loaded", k), wl[k], m_wl[k]);
          chk($sformatf("c%0d ovf", k), ov[k], m_ovf[k]);
        end
      end
    end
  end

  task automatic idle();
    clear = 0; drain = 0; load_w = 0; psum0 = '0; psum0_v = 0;
    for (int k = 0; k < 3; k++) begin a[k] = '0; b[k] = '0; av[k] = 0; bv[k] = 0; end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pair(input int k, input logic [DW-1:0] x, input logic [DW-1:0] y);
    a[k] = x; b[k] = y; av[k] = 1; bv[k] = 1;
  endtask

  initial begin
    idle(); mode = 0; reset = 1;
    cyc(); cyc();
    chk("reset out_psum", po[2], 0);
    chk("reset out_psum_valid", pov[2], 0);
    chk("reset w_loaded", wl[2], 0);
    chk("reset ovf", ov[2], 0);
    chk("reset out_a", oa[2], 0);
    reset = 0;
    cyc();

    // OS dot product: 3*4 - 2*5 + 7*7 = 51
    pair(2, 8'd3, 8'd4); cyc();
    pair(2, 8'hFE, 8'd5); cyc();
    pair(2, 8'd7, 8'd7); cyc();
    idle(); drain = 1; cyc();
    chk("os dot psum", $signed(po[2]), 51);
    chk("os dot valid", pov[2], 1);
    drain = 0; cyc();
    drain = 1; cyc();
    chk("os acc zero after drain", $signed(po[2]), 0);
    drain = 0; cyc(); cyc();

    // clear with a pair restarts the tile at the product
    pair(2, 8'd3, 8'd4); cyc();
    pair(2, 8'hFE, 8'd5); cyc();
    pair(2, 8'd7, 8'd7); cyc();
    pair(2, 8'd2, 8'd3); clear = 1; cyc();
    idle(); drain = 1; cyc();
    chk("os clear psum", $signed(po[2]), 6);
    drain = 0; cyc();

    // 3-row drain chain: tiles 10,20,30 emerge bottom-first
    pair(0, 8'd2, 8'd5); pair(1, 8'd4, 8'd5); pair(2, 8'd5, 8'd6); cyc();
    idle(); drain = 1; cyc();
    chk("chain 0", $signed(po[2]), 30);
    chk("chain 0 valid", pov[2], 1);
    cyc();
    chk("chain 1", $signed(po[2]), 20);
    cyc();
    chk("chain 2", $signed(po[2]), 10);
    chk("chain 2 valid", pov[2], 1);
    drain = 0; cyc(); cyc();

    // Saturation / wrap: 3 x 127*127 = 48387 in 16 bits
    pair(2, 8'd127, 8'd127); cyc(); cyc(); cyc();
    idle();
`ifdef PE_SAT_EN
    chk("sat ovf", ov[2], 1);
`else
    chk("wrap ovf", ov[2], 0);
`endif
    drain = 1; cyc();
`ifdef PE_SAT_EN
    chk("sat psum", $signed(po[2]), 32767);
`else
    chk("wrap psum", $signed(po[2]), -17149);
`endif

    // Reset while in S_DRAIN with drain still held
    a[2] = 8'd9; av[2] = 1; reset = 1; cyc();
    chk("reset mid-drain out_psum", po[2], 0);
    chk("reset mid-drain valid", pov[2], 0);
    chk("reset mid-drain ovf", ov[2], 0);
    chk("reset mid-drain out_a", oa[2], 0);
    reset = 0; idle(); cyc();

    // Mode 0->1 with a non-zero accumulator
    pair(2, 8'd2, 8'd2); cyc();
    idle(); mode = 1; cyc();
    chk("mode chg acc", $signed(u_c2.r_acc), 0);
    chk("mode chg w_loaded", wl[2], 0);

    // WS: w=-3, 100 + 5*(-3) = 85
    load_w = 1; b[0] = 8'hFD; bv[0] = 1; cyc();
    chk("ws w_loaded", wl[0], 1);
    idle(); a[0] = 8'd5; av[0] = 1; psum0 = 16'd100; psum0_v = 1; cyc();
    chk("ws psum", $signed(po[0]), 85);
    chk("ws psum valid", pov[0], 1);
    chk("ws out_a", oa[0], 5);
    idle(); a[1] = 8'd7; av[1] = 1; cyc();
    chk("ws passthrough", $signed(po[1]), 85);
    // Concurrent load: old weight -3 used, new weight 4 next cycle
    idle(); load_w = 1; b[0] = 8'd4; bv[0] = 1; a[0] = 8'd1; av[0] = 1; psum0_v = 1; cyc();
    chk("ws old weight", $signed(po[0]), -3);
    idle(); a[0] = 8'd1; av[0] = 1; psum0_v = 1; cyc();
    chk("ws new weight", $signed(po[0]), 4);
    idle(); mode = 0; cyc();
    chk("mode back w_loaded", wl[0], 0);
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
